// File: rtl/sll_seq.sv
// Multi-cycle logical left shifter: one log-shifter stage (1, 2, 4, 8, 16) per clock,
// with start/busy/done handshake and shifted-out-ones flag. Optional early exit: SLL_SEQ_EARLY_EXIT_EN.
module sll_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               ovf
);

    localparam int STAGE_W = $clog2(SHAMT_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     data, data_next;
    logic [SHAMT_W-1:0]   amount, amount_next;
    logic [STAGE_W-1:0]   stage, stage_next;
    logic                 ovf_acc, ovf_acc_next;
    logic                 busy_next, done_next, ovf_next;
    logic [WIDTH-1:0]     result_next;

    logic [WIDTH-1:0]     stage_shift;
    logic                 stage_lost;
    logic                 stage_bit;
    logic                 upper_zero;
    logic                 stage_last;

    // Each stage uses a fixed shift distance, so only one constant-shift mux layer is active per cycle
    always_comb begin
        stage_shift = data;
        stage_lost  = 1'b0;
        stage_bit   = 1'b0;
        upper_zero  = 1'b0;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (stage == STAGE_W'(k)) begin
                stage_shift = data << (2 ** k);
                stage_lost  = |(data >> (WIDTH - 2 ** k));
                stage_bit   = amount[k];
                upper_zero  = ((amount >> (k + 1)) == '0);
            end
        end
    end

`ifdef SLL_SEQ_EARLY_EXIT_EN
    assign stage_last = upper_zero;
`else
    assign stage_last = (stage == STAGE_W'(SHAMT_W - 1));
`endif

    always_comb begin
        state_next   = state;
        data_next    = data;
        amount_next  = amount;
        stage_next   = stage;
        ovf_acc_next = ovf_acc;
        busy_next    = busy;
        done_next    = 1'b0;
        result_next  = result;
        ovf_next     = ovf;

        case (state)
            IDLE, DONE: begin
                // DONE accepts a new request just like IDLE, giving back-to-back issue
                if (start) begin
                    data_next    = a;
                    amount_next  = shamt;
                    stage_next   = '0;
                    ovf_acc_next = 1'b0;
                    busy_next    = 1'b1;
                    state_next   = SHIFT;
                end else begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (stage_bit) begin
                    data_next    = stage_shift;
                    ovf_acc_next = ovf_acc | stage_lost;
                end
                stage_next = stage + STAGE_W'(1);
                if (stage_last) begin
                    state_next  = DONE;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    result_next = data_next;
                    ovf_next    = ovf_acc_next;
                end
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data    <= '0;
            amount  <= '0;
            stage   <= '0;
            ovf_acc <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
        end else begin
            data    <= data_next;
            amount  <= amount_next;
            stage   <= stage_next;
            ovf_acc <= ovf_acc_next;
            busy    <= busy_next;
            done    <= done_next;
            result  <= result_next;
            ovf     <= ovf_next;
        end
    end

endmodule

// File: tb/tb_sll_seq.sv
// Self-checking bench for sll_seq: cycle-level scoreboard model plus directed literal checks.
module tb_sll_seq;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;

    int checks = 0;
    int passes = 0;

    sll_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int exp_lat(input logic [4:0] s);
        int h;
        h = 0;
`ifdef SLL_SEQ_EARLY_EXIT_EN
        for (int i = 0; i < 5; i++) if (s[i]) h = i + 1;
        if (h < 1) h = 1;
`else
        h = 5;
`endif
        return h;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard: counts down the remaining latency of an accepted request
    logic        m_busy, m_done, m_ovf, p_ovf;
    logic [31:0] m_result, p_result;
    int          remaining;

    always @(posedge clock or negedge reset_n) begin
        logic [63:0] wide;
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_result = 0; m_ovf = 0; remaining = 0;
        end else begin
            m_done = 0;
            if (remaining != 0) begin
                remaining--;
                if (remaining == 0) begin
                    m_busy = 0; m_done = 1; m_result = p_result; m_ovf = p_ovf;
                end
            end else if (start) begin
                wide      = {32'd0, a} << shamt;
                p_result  = wide[31:0];
                p_ovf     = |wide[63:32];
                remaining = exp_lat(shamt);
                m_busy    = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            check_output("busy", {31'd0, busy}, {31'd0, m_busy});
            check_output("done", {31'd0, done}, {31'd0, m_done});
            check_output("result", result, m_result);
            check_output("ovf", {31'd0, ovf}, {31'd0, m_ovf});
        end
    end

    task automatic apply_stimulus(input logic [31:0] av, input logic [4:0] sv);
        @(negedge clock);
        start = 1'b1; a = av; shamt = sv;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_n, input logic [31:0] exp_res, input logic exp_ovf);
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_output({name, " latency"}, n, exp_n);
        check_output({name, " result"}, result, exp_res);
        check_output({name, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; a = '0; shamt = '0;
        #12;
        check_output("reset busy", {31'd0, busy}, 32'd0);
        check_output("reset done", {31'd0, done}, 32'd0);
        check_output("reset result", result, 32'd0);
        check_output("reset ovf", {31'd0, ovf}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        apply_stimulus(32'h0000_0001, 5'd31);
        check_output("t1 busy", {31'd0, busy}, 32'd1);
        wait_done("t1", exp_lat(5'd31), 32'h8000_0000, 1'b0);

        apply_stimulus(32'hF000_000F, 5'd4);
        wait_done("t2", exp_lat(5'd4), 32'h0000_00F0, 1'b1);

        apply_stimulus(32'h1234_5678, 5'd0);
        wait_done("t3", exp_lat(5'd0), 32'h1234_5678, 1'b0);

        apply_stimulus(32'h8000_0000, 5'd1);
        wait_done("t4", exp_lat(5'd1), 32'h0000_0000, 1'b1);

        apply_stimulus(32'h0000_FFFF, 5'd16);
        wait_done("t5", exp_lat(5'd16), 32'hFFFF_0000, 1'b0);

        // A second start during SHIFT must not disturb the running shift
        apply_stimulus(32'h0000_0001, 5'd1);
        @(negedge clock);
        start = 1'b1; a = 32'h0000_0002; shamt = 5'd2;
        @(negedge clock);
        start = 1'b0;
`ifndef SLL_SEQ_EARLY_EXIT_EN
        wait_done("t6", 3, 32'h0000_0002, 1'b0);
`endif
        repeat (8) @(negedge clock);

        // Start held through the DONE cycle issues a second operation back to back
        @(negedge clock);
        start = 1'b1; a = 32'h0000_0003; shamt = 5'd1;
        @(negedge clock);
        shamt = 5'd3;
        wait_done("t7a", exp_lat(5'd1), 32'h0000_0006, 1'b0);
        @(negedge clock);
        start = 1'b0;
        wait_done("t7b", exp_lat(5'd3), 32'h0000_0018, 1'b0);

        // Asynchronous reset in the middle of a shift
        apply_stimulus(32'hF000_000F, 5'd31);
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("mid reset busy", {31'd0, busy}, 32'd0);
        check_output("mid reset done", {31'd0, done}, 32'd0);
        check_output("mid reset result", result, 32'd0);
        check_output("mid reset ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);

        apply_stimulus(32'hFFFF_FFFF, 5'd16);
        wait_done("t8", exp_lat(5'd16), 32'hFFFF_0000, 1'b1);
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
